rcc_vdd_rsr_bank: RTL and testbench
===================================

RCC_VDD_RSR_BANK -- requirements
Module: rcc_vdd_rsr_bank

Interface
REQ-001 Parameter NUM_CPU, default 2: number of per-CPU reset-status register copies.
REQ-002 Parameter NUM_SRC, default 14: number of reset-cause sources and flags per CPU.
REQ-003 Parameter RST_MASK, NUM_SRC bits, default 14'h0100: flag values loaded at reset (bit 8 = POR flag).
REQ-004 Parameter TMO_W, default 8: LSI startup timeout counter width.
REQ-005 Parameter LSI_TMO, default 8'd200: LSI startup timeout in clk cycles.
REQ-006 Port clk, input, 1: single clock for all state.
REQ-007 Port rst_n, input, 1: reset, asynchronous and active-low; driven at integration from ~pwr_por_rst.
REQ-008 Port rst_src, input, NUM_SRC: asynchronous reset-cause levels, active high, default 0.
REQ-009 Port wdata, input, 1: write data bit shared by all write strobes.
REQ-010 Port rmvf_wren, input, NUM_CPU: per-CPU RMVF write strobe, one clk wide.
REQ-011 Port lsion_wren, input, 1: LSION write strobe, one clk wide.
REQ-012 Port lsi_rdy, input, 1: asynchronous LSI oscillator ready.
REQ-013 Port rsr_flags, output, NUM_CPU*NUM_SRC: flags; CPU c, source s at bit c*NUM_SRC+s.
REQ-014 Port rsr_rmvf, output, NUM_CPU: per-CPU RMVF register.
REQ-015 Port lsion, output, 1: LSI enable register.
REQ-016 Port lsirdy, output, 1: LSI ready status, high only in state RDY.
REQ-017 Port lsi_fail, output, 1: sticky LSI startup timeout flag.

Function
REQ-018 Each rst_src bit and lsi_rdy SHALL pass through a 2-flop synchronizer before any use.
REQ-019 A rising edge SHALL be detected on each synchronized rst_src bit with a third flop; this gives 3 clk latency from the input change to the edge pulse.
REQ-020 In the cycle after an edge pulse on source s, flag s SHALL be set in every CPU copy whose rsr_rmvf bit is 0.
REQ-021 A flag SHALL stay set until cleared; it SHALL ignore further edges and a held-high source.
REQ-022 On rmvf_wren[c], rsr_rmvf[c] SHALL load wdata the next cycle.
REQ-023 While rsr_rmvf[c]=1, all flags of CPU c SHALL be held at 0 and set events for CPU c SHALL be discarded, with no deferred set.
REQ-024 If the rmvf_wren[c] write with wdata=1 and a set event fall in the same cycle, the clear SHALL win for CPU c; other CPUs SHALL still set.
REQ-025 The CPU copies SHALL be independent: clearing one SHALL never alter another.
REQ-026 On lsion_wren, lsion SHALL load wdata the next cycle.
REQ-027 The LSI FSM SHALL have states OFF, WAIT, RDY and FAIL.
REQ-028 LSI FSM transitions SHALL be as follows:
 - OFF to WAIT when lsion becomes 1; counter loads LSI_TMO.
 - WAIT to RDY when synced lsi_rdy=1.
 - WAIT, counter decrements each cycle; at 0 with lsi_rdy low, go to FAIL.
 - RDY to WAIT when synced lsi_rdy falls; counter reloads LSI_TMO.
 - FAIL holds until lsion becomes 0.
 - Any state to OFF when lsion=0.
REQ-029 lsi_fail SHALL be set on entry to FAIL and cleared only by writing lsion=1 (re-arm) or by reset.
REQ-030 If synced lsi_rdy=1 in the same cycle the counter reaches 0, the FSM SHALL go to RDY, not FAIL.
REQ-031 The counter SHALL saturate at 0 and never wrap.

Reset
REQ-032 On rst_n low, all copies of rsr_flags SHALL load RST_MASK; rsr_rmvf, lsion, lsirdy and lsi_fail SHALL go to 0; the FSM SHALL go to OFF; all synchronizer and edge flops SHALL go to 0.
REQ-033 A source held high through reset release SHALL NOT produce an edge; its edge flop SHALL follow the synchronizer after release.
REQ-034 Reset asserted mid-startup (WAIT) SHALL abort startup with no lsi_fail.

Verification
REQ-035 Release reset with NUM_CPU=2 -> rsr_flags = {14'h0100,14'h0100}, lsirdy=0, lsion=0.
REQ-036 Pulse rst_src[3] high for 5 cycles -> bit 3 and bit 17 set 4 cycles after the rise; a second pulse gives no change.
REQ-037 Write rmvf_wren=2'b01 with wdata=1 in the same cycle as a rst_src[3] edge event -> CPU0 flags=0 and rsr_rmvf=01; CPU1 bit 17=1. Then write wdata=0 and pulse again -> CPU0 bit 3 sets.
REQ-038 Write lsion=1 and raise lsi_rdy 10 cycles later -> WAIT then RDY; lsirdy=1 at 10+2 sync+1 cycles.
REQ-039 Write lsion=1 with lsi_rdy held 0 and LSI_TMO=200 -> FAIL after 201 cycles and lsi_fail=1; write lsion=0 then 1 -> lsi_fail=0, WAIT.
REQ-040 Assert rst_n during WAIT -> OFF, all outputs at reset values, lsi_fail=0.

Source files
------------

// File: rtl/rcc_vdd_rsr_bank.sv
// rcc_vdd_rsr_bank: per-CPU reset-status flag bank with RMVF clear and LSI startup supervisor
module rcc_vdd_rsr_bank #(
    parameter int                  NUM_CPU  = 2,
    parameter int                  NUM_SRC  = 14,
    parameter logic [NUM_SRC-1:0]  RST_MASK = 14'h0100,
    parameter int                  TMO_W    = 8,
    parameter logic [TMO_W-1:0]    LSI_TMO  = 8'd200
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          rst_src,
    input  logic                        wdata,
    input  logic [NUM_CPU-1:0]          rmvf_wren,
    input  logic                        lsion_wren,
    input  logic                        lsi_rdy,
    output logic [NUM_CPU*NUM_SRC-1:0]  rsr_flags,
    output logic [NUM_CPU-1:0]          rsr_rmvf,
    output logic                        lsion,
    output logic                        lsirdy,
    output logic                        lsi_fail
);

    typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_RDY, ST_FAIL} lsi_state_t;

    logic [NUM_SRC-1:0]              src_s1, src_s2, src_d, src_ev;
    logic [1:0]                      warm;
    logic [NUM_CPU-1:0][NUM_SRC-1:0] flags;
    logic [NUM_CPU-1:0]              clr;
    logic                            rdy_s1, rdy_s2;
    lsi_state_t                      state, state_n;
    logic [TMO_W-1:0]                cnt, cnt_n;
    logic                            fail_n;

    // A pending or present RMVF=1 blanks that CPU's flags and swallows its set events
    assign clr       = rsr_rmvf | (rmvf_wren & {NUM_CPU{wdata}});
    assign rsr_flags = flags;
    assign lsirdy    = (state == ST_RDY);

    // Source synchronizers, edge flop and registered rising-edge pulse; pulses stay
    // masked until the pipeline has refilled after reset so a level held through reset is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_s1 <= '0;
            src_s2 <= '0;
            src_d  <= '0;
            src_ev <= '0;
            warm   <= '0;
        end else begin
            src_s1 <= rst_src;
            src_s2 <= src_s1;
            src_d  <= src_s2;
            warm   <= (warm == 2'd3) ? warm : warm + 2'd1;
            src_ev <= (warm == 2'd3) ? (src_s2 & ~src_d) : '0;
        end
    end

    // Per-CPU sticky flags and RMVF registers; each copy only looks at its own clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags    <= {NUM_CPU{RST_MASK}};
            rsr_rmvf <= '0;
        end else begin
            for (int c = 0; c < NUM_CPU; c++)
                flags[c] <= clr[c] ? '0 : (flags[c] | src_ev);
            rsr_rmvf <= (rmvf_wren & {NUM_CPU{wdata}}) | (~rmvf_wren & rsr_rmvf);
        end
    end

    // LSION register, LSI ready synchronizer and supervisor state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsion    <= 1'b0;
            rdy_s1   <= 1'b0;
            rdy_s2   <= 1'b0;
            state    <= ST_OFF;
            cnt      <= '0;
            lsi_fail <= 1'b0;
        end else begin
            lsion    <= lsion_wren ? wdata : lsion;
            rdy_s1   <= lsi_rdy;
            rdy_s2   <= rdy_s1;
            state    <= state_n;
            cnt      <= cnt_n;
            lsi_fail <= fail_n;
        end
    end

    // Startup supervisor: ready beats timeout when both happen together; counter never wraps
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_OFF: begin
                if (lsion) begin
                    state_n = ST_WAIT;
                    cnt_n   = LSI_TMO;
                end
            end
            ST_WAIT: begin
                if (rdy_s2)
                    state_n = ST_RDY;
                else if (cnt == '0)
                    state_n = ST_FAIL;
                else
                    cnt_n = cnt - TMO_W'(1);
            end
            ST_RDY: begin
                if (!rdy_s2) begin
                    state_n = ST_WAIT;
                    cnt_n   = LSI_TMO;
                end
            end
            default: state_n = ST_FAIL;
        endcase
        if (!lsion)
            state_n = ST_OFF;
        fail_n = (state_n == ST_FAIL && state != ST_FAIL) ? 1'b1 :
                 (lsion_wren && wdata) ? 1'b0 : lsi_fail;
    end

endmodule

// File: tb/tb_rcc_vdd_rsr_bank.sv
// tb_rcc_vdd_rsr_bank: randomized and directed checks of the reset-status bank against a behavioural model
module tb_rcc_vdd_rsr_bank;

    localparam logic [13:0] MASK = 14'h0100;
    localparam int TMO = 200;
    localparam int M_OFF = 0, M_WAIT = 1, M_RDY = 2, M_FAIL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [13:0] rst_src = '0;
    logic        wdata = 1'b0;
    logic [1:0]  rmvf_wren = '0;
    logic        lsion_wren = 1'b0;
    logic        lsi_rdy = 1'b0;
    logic [27:0] rsr_flags;
    logic [1:0]  rsr_rmvf;
    logic        lsion, lsirdy, lsi_fail;

    int checks = 0;
    int failures = 0;

    logic [13:0] m_flags [2];
    logic [1:0]  m_rmvf;
    bit          m_lsion, m_fail;
    int          m_state, m_cnt;
    logic [13:0] sq [$];
    bit          lq [$];

    rcc_vdd_rsr_bank dut (
        .clk(clk), .rst_n(rst_n), .rst_src(rst_src), .wdata(wdata),
        .rmvf_wren(rmvf_wren), .lsion_wren(lsion_wren), .lsi_rdy(lsi_rdy),
        .rsr_flags(rsr_flags), .rsr_rmvf(rsr_rmvf), .lsion(lsion),
        .lsirdy(lsirdy), .lsi_fail(lsi_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags[0] = MASK;
        m_flags[1] = MASK;
        m_rmvf  = '0;
        m_lsion = 1'b0;
        m_fail  = 1'b0;
        m_state = M_OFF;
        m_cnt   = 0;
        sq.delete();
        lq.delete();
    endtask

    // One clock edge of the specified behaviour; sources count as edges only between two post-reset samples
    task automatic model_edge();
        int n;
        logic [13:0] ev;
        bit rs, old_l;
        int ns;
        sq.push_back(rst_src);
        n  = sq.size();
        ev = (n >= 5) ? (sq[n-4] & ~sq[n-5]) : 14'h0;
        for (int c = 0; c < 2; c++) begin
            if (m_rmvf[c] || (rmvf_wren[c] && wdata)) m_flags[c] = '0;
            else m_flags[c] = m_flags[c] | ev;
            if (rmvf_wren[c]) m_rmvf[c] = wdata;
        end
        lq.push_back(lsi_rdy);
        rs = (lq.size() >= 3) ? lq[lq.size()-3] : 1'b0;
        old_l = m_lsion;
        if (lsion_wren) m_lsion = wdata;
        ns = m_state;
        if (!old_l) ns = M_OFF;
        else if (m_state == M_OFF) begin ns = M_WAIT; m_cnt = TMO; end
        else if (m_state == M_WAIT) begin
            if (rs) ns = M_RDY;
            else if (m_cnt == 0) ns = M_FAIL;
            else m_cnt = m_cnt - 1;
        end
        else if (m_state == M_RDY && !rs) begin ns = M_WAIT; m_cnt = TMO; end
        if (ns == M_FAIL && m_state != M_FAIL) m_fail = 1'b1;
        else if (lsion_wren && wdata) m_fail = 1'b0;
        m_state = ns;
    endtask

    task automatic cmp_all();
        chk("flags",    64'(rsr_flags), 64'({m_flags[1], m_flags[0]}));
        chk("rmvf",     64'(rsr_rmvf),  64'(m_rmvf));
        chk("lsion",    64'(lsion),     64'(m_lsion));
        chk("lsirdy",   64'(lsirdy),    64'(m_state == M_RDY));
        chk("lsi_fail", 64'(lsi_fail),  64'(m_fail));
    endtask

    task automatic step(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            model_edge();
            #1;
            cmp_all();
        end
    endtask

    task automatic do_reset(input logic [13:0] hold);
        rst_n = 1'b0;
        rst_src = hold;
        wdata = 1'b0;
        rmvf_wren = '0;
        lsion_wren = 1'b0;
        lsi_rdy = 1'b0;
        #1;
        chk("rst_flags",  64'(rsr_flags), 64'({MASK, MASK}));
        chk("rst_rmvf",   64'(rsr_rmvf),  64'd0);
        chk("rst_lsion",  64'(lsion),     64'd0);
        chk("rst_lsirdy", 64'(lsirdy),    64'd0);
        chk("rst_fail",   64'(lsi_fail),  64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_lsion(input bit v);
        lsion_wren = 1'b1;
        wdata = v;
        step();
        lsion_wren = 1'b0;
        wdata = 1'b0;
    endtask

    initial begin
        #2;
        do_reset('0);
        step(6);

        // first pulse sets the flag in both copies on the fourth edge after the rise
        rst_src[3] = 1'b1;
        step(3);
        chk("b3_early", 64'(rsr_flags[3]), 64'd0);
        step();
        chk("b3_set",   64'(rsr_flags[3]),  64'd1);
        chk("b17_set",  64'(rsr_flags[17]), 64'd1);
        step();
        rst_src[3] = 1'b0;
        step(5);
        rst_src[3] = 1'b1;
        step(5);
        rst_src[3] = 1'b0;
        step(6);
        chk("second_pulse", 64'(rsr_flags), 64'({14'h0108, 14'h0108}));

        // clear of CPU0 coincides with a set event: CPU0 clears, CPU1 sets
        rst_src[3] = 1'b1;
        step(3);
        rmvf_wren = 2'b01;
        wdata = 1'b1;
        step();
        rmvf_wren = '0;
        wdata = 1'b0;
        chk("cpu0_clr",  64'(rsr_flags[13:0]), 64'd0);
        chk("rmvf_01",   64'(rsr_rmvf), 64'd1);
        chk("cpu1_b17",  64'(rsr_flags[17]), 64'd1);
        step(2);
        rst_src[3] = 1'b0;
        step(4);
        rmvf_wren = 2'b01;
        step();
        rmvf_wren = '0;
        chk("rmvf_00", 64'(rsr_rmvf), 64'd0);
        rst_src[3] = 1'b1;
        step(4);
        chk("cpu0_reset", 64'(rsr_flags[3]), 64'd1);
        rst_src[3] = 1'b0;
        step(4);

        // LSI ready 10 cycles after enable, seen 3 edges after the rise
        write_lsion(1'b1);
        chk("lsion_on", 64'(lsion), 64'd1);
        step(10);
        chk("lsi_wait", 64'(lsirdy), 64'd0);
        lsi_rdy = 1'b1;
        step(2);
        chk("lsi_rdy_lat2", 64'(lsirdy), 64'd0);
        step();
        chk("lsi_rdy_lat3", 64'(lsirdy), 64'd1);

        // startup timeout
        lsi_rdy = 1'b0;
        step(3);
        write_lsion(1'b0);
        write_lsion(1'b1);
        step(201);
        chk("tmo_not_yet", 64'(lsi_fail), 64'd0);
        step();
        chk("tmo_fail", 64'(lsi_fail), 64'd1);
        write_lsion(1'b0);
        chk("fail_sticky", 64'(lsi_fail), 64'd1);
        write_lsion(1'b1);
        chk("fail_rearm", 64'(lsi_fail), 64'd0);
        step();
        chk("rearm_wait", 64'(lsirdy), 64'd0);

        // reset in the middle of startup
        step(5);
        do_reset(14'h0020);
        step(8);
        chk("held_src", 64'(rsr_flags), 64'({MASK, MASK}));
        rst_src = '0;
        step(4);
        rst_src[5] = 1'b1;
        step(4);
        chk("held_b5",  64'(rsr_flags[5]),  64'd1);
        chk("held_b19", 64'(rsr_flags[19]), 64'd1);
        rst_src = '0;
        step(4);

        // random traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset(14'($urandom));
                rst_src = '0;
            end
            if ($urandom_range(0, 7) == 0) rst_src[$urandom_range(0, 13)] ^= 1'b1;
            rmvf_wren  = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            lsion_wren = ($urandom_range(0, 39) == 0);
            wdata      = 1'($urandom);
            if ($urandom_range(0, 59) == 0) lsi_rdy = ~lsi_rdy;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
